// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide memory port between the processor
// (port 0) and a second bus master (port 1). Each access runs
// IDLE -> ACCESS (MEM_LAT strobe cycles) -> DONE (one-cycle ack).
//
// Build option: define ARB_FIXED_PRIO_EN to make port 0 win every conflict
// (lock still honoured). Left undefined, conflicts are resolved round-robin.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no access in flight; grant a requester if any
// ACCESS | memread/memwrite asserted for MEM_LAT cycles
// DONE   | strobes low, ack pulses to the owner
module mem_arbiter #(
    parameter int WIDTH   = 8,
    parameter int MEM_LAT = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             req0_i,
    input  logic             req1_i,
    input  logic             we0_i,
    input  logic             we1_i,
    input  logic             lock0_i,
    input  logic             lock1_i,
    input  logic [WIDTH-1:0] addr0_i,
    input  logic [WIDTH-1:0] addr1_i,
    input  logic [WIDTH-1:0] wdata0_i,
    input  logic [WIDTH-1:0] wdata1_i,
    output logic             ack0_o,
    output logic             ack1_o,
    output logic [WIDTH-1:0] rdata0_o,
    output logic [WIDTH-1:0] rdata1_o,
    output logic             memread_o,
    output logic             memwrite_o,
    output logic [WIDTH-1:0] mar_o,
    output logic [WIDTH-1:0] writedata_o,
    input  logic [WIDTH-1:0] memdata_i,
    output logic             busy_o,
    output logic             owner_o
);

    localparam int CW = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             we_q, we_d;
    logic             lock_q, lock_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] mar_q, mar_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata0_q, rdata0_d;
    logic [WIDTH-1:0] rdata1_q, rdata1_d;
    logic             owner_req;
    logic             win;

    // State and datapath registers; reset leaves last-served at 1 so port 0 wins first.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            lock_q   <= 1'b0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            mar_q    <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            lock_q   <= lock_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            mar_q    <= mar_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Winner selection, next state, grant capture and read-data capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        lock_d   = lock_q;
        owner_d  = owner_q;
        last_d   = last_q;
        mar_d    = mar_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        owner_req = owner_q ? req1_i : req0_i;

        // A held lock only counts while its owner is still requesting;
        // otherwise it is dropped and this cycle arbitrates normally.
        if (lock_q && owner_req) begin
            win = owner_q;
        end else if (req0_i && req1_i) begin
`ifdef ARB_FIXED_PRIO_EN
            win = 1'b0;
`else
            win = ~last_q;
`endif
        end else if (req1_i) begin
            win = 1'b1;
        end else begin
            win = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (req0_i || req1_i) begin
                    state_d = S_ACCESS;
                    cnt_d   = '0;
                    owner_d = win;
                    last_d  = win;
                    we_d    = win ? we1_i    : we0_i;
                    lock_d  = win ? lock1_i  : lock0_i;
                    mar_d   = win ? addr1_i  : addr0_i;
                    wdata_d = win ? wdata1_i : wdata0_i;
                end else begin
                    lock_d = 1'b0;
                end
            end
            S_ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    if (!we_q) begin
                        if (owner_q) rdata1_d = memdata_i;
                        else         rdata0_d = memdata_i;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes, ack and status decoded from the registered state.
    always_comb begin
        memread_o  = (state_q == S_ACCESS) && !we_q;
        memwrite_o = (state_q == S_ACCESS) &&  we_q;
        ack0_o     = (state_q == S_DONE)   && !owner_q;
        ack1_o     = (state_q == S_DONE)   &&  owner_q;
        busy_o     = (state_q != S_IDLE);
    end

    assign mar_o       = mar_q;
    assign writedata_o = wdata_q;
    assign rdata0_o    = rdata0_q;
    assign rdata1_o    = rdata1_q;
    assign owner_o     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance a uses MEM_LAT=2, instance b
// MEM_LAT=1. The memory model returns addr ^ 0xB5 for any read.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    int         checks = 0;
    int         errors = 0;

    logic       req0, req1, we0, we1, lock0, lock1;
    logic [7:0] addr0, addr1, wdata0, wdata1, memdata;
    logic       ack0, ack1, memread, memwrite, busy, owner;
    logic [7:0] rdata0, rdata1, mar, writedata;

    logic       b_req0, b_req1, b_we0, b_we1, b_lock0, b_lock1;
    logic [7:0] b_addr0, b_addr1, b_wdata0, b_wdata1, b_memdata;
    logic       b_ack0, b_ack1, b_memread, b_memwrite, b_busy, b_owner;
    logic [7:0] b_rdata0, b_rdata1, b_mar, b_writedata;

    assign memdata   = mar ^ 8'hB5;
    assign b_memdata = b_mar ^ 8'hB5;

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(8), .MEM_LAT(2)) u_a (
        .clk_i(clk), .reset_i(reset),
        .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
        .lock0_i(lock0), .lock1_i(lock1),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .ack0_o(ack0), .ack1_o(ack1), .rdata0_o(rdata0), .rdata1_o(rdata1),
        .memread_o(memread), .memwrite_o(memwrite), .mar_o(mar),
        .writedata_o(writedata), .memdata_i(memdata),
        .busy_o(busy), .owner_o(owner)
    );

    mem_arbiter #(.WIDTH(8), .MEM_LAT(1)) u_b (
        .clk_i(clk), .reset_i(reset),
        .req0_i(b_req0), .req1_i(b_req1), .we0_i(b_we0), .we1_i(b_we1),
        .lock0_i(b_lock0), .lock1_i(b_lock1),
        .addr0_i(b_addr0), .addr1_i(b_addr1), .wdata0_i(b_wdata0), .wdata1_i(b_wdata1),
        .ack0_o(b_ack0), .ack1_o(b_ack1), .rdata0_o(b_rdata0), .rdata1_o(b_rdata1),
        .memread_o(b_memread), .memwrite_o(b_memwrite), .mar_o(b_mar),
        .writedata_o(b_writedata), .memdata_i(b_memdata),
        .busy_o(b_busy), .owner_o(b_owner)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({memread, memwrite, ack0, ack1, busy, owner} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 000000", {memread, memwrite, ack0, ack1, busy, owner});
        end
        checks++;
        if ({mar, writedata, rdata0, rdata1} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got %h exp 00000000", {mar, writedata, rdata0, rdata1});
        end
        checks++;
        if ({b_memread, b_memwrite, b_ack0, b_ack1, b_busy, b_owner} !== 6'b0) begin
            errors++;
            $display("FAIL reset_b_ctrl got %b exp 000000", {b_memread, b_memwrite, b_ack0, b_ack1, b_busy, b_owner});
        end
        reset = 1'b0;
    endtask

    task automatic test_port0_read();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if ({memread, memwrite, busy, owner} !== 4'b1010 || mar !== 8'h10) begin
                errors++;
                $display("FAIL p0_read_strobe cyc %0d got rd/wr/busy/own=%b mar=%h exp 1010 mar=10",
                         c, {memread, memwrite, busy, owner}, mar);
            end
        end
        step();
        checks++;
        if ({ack0, ack1, memread} !== 3'b100) begin
            errors++;
            $display("FAIL p0_read_ack got ack0/ack1/rd=%b exp 100", {ack0, ack1, memread});
        end
        checks++;
        if (rdata0 !== 8'hA5) begin
            errors++;
            $display("FAIL p0_read_data got %h exp a5", rdata0);
        end
        req0 = 1'b0;
        step();
        checks++;
        if ({ack0, ack1, busy} !== 3'b000) begin
            errors++;
            $display("FAIL p0_read_idle got %b exp 000", {ack0, ack1, busy});
        end
    endtask

    task automatic test_port1_write();
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; wdata1 = 8'h3C;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if ({memwrite, memread, owner} !== 3'b101 || writedata !== 8'h3C || mar !== 8'h20) begin
                errors++;
                $display("FAIL p1_write_strobe cyc %0d got wr/rd/own=%b wd=%h mar=%h exp 101 wd=3c mar=20",
                         c, {memwrite, memread, owner}, writedata, mar);
            end
        end
        step();
        checks++;
        if ({ack1, ack0, memwrite} !== 3'b100) begin
            errors++;
            $display("FAIL p1_write_ack got ack1/ack0/wr=%b exp 100", {ack1, ack0, memwrite});
        end
        checks++;
        if (rdata1 !== 8'h00) begin
            errors++;
            $display("FAIL p1_write_rdata got %h exp 00", rdata1);
        end
        req1 = 1'b0; we1 = 1'b0;
        step();
        checks++;
        if ({ack0, ack1, busy} !== 3'b000) begin
            errors++;
            $display("FAIL p1_write_single_ack got %b exp 000", {ack0, ack1, busy});
        end
    endtask

    task automatic test_round_robin();
        int   cyc_at[4];
        logic port_at[4];
        logic exp_port[4];
        int   n = 0;
`ifdef ARB_FIXED_PRIO_EN
        exp_port = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_port = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 8'h30; addr1 = 8'h31; lock0 = 1'b0; lock1 = 1'b0;
        for (int c = 1; c <= 40 && n < 4; c++) begin
            step();
            checks++;
            if (ack0 && ack1) begin
                errors++;
                $display("FAIL rr_dual_ack cyc %0d got both acks exp at most one", c);
            end
            if (ack0 || ack1) begin
                cyc_at[n]  = c;
                port_at[n] = ack1;
                checks++;
                if (ack1 ? (rdata1 !== 8'h84) : (rdata0 !== 8'h85)) begin
                    errors++;
                    $display("FAIL rr_rdata ack %0d got r0=%h r1=%h exp %s", n, rdata0, rdata1,
                             ack1 ? "r1=84" : "r0=85");
                end
                n++;
                if (n == 4) begin
                    req0 = 1'b0; req1 = 1'b0;
                end
            end
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL rr_timeout got %0d acks exp 4", n);
        end else begin
            checks++;
            if (cyc_at[0] != 3) begin
                errors++;
                $display("FAIL rr_first_latency got %0d exp 3", cyc_at[0]);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (port_at[i] !== exp_port[i]) begin
                    errors++;
                    $display("FAIL rr_grant %0d got port %0d exp %0d", i, port_at[i], exp_port[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (cyc_at[i] - cyc_at[i-1] != 4) begin
                        errors++;
                        $display("FAIL rr_gap %0d got %0d exp 4", i, cyc_at[i] - cyc_at[i-1]);
                    end
                end
            end
        end
        step();
    endtask

    task automatic test_lock();
        logic port_seq[5];
        int   n = 0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h40; lock1 = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h00; lock0 = 1'b1;
        for (int c = 1; c <= 60 && n < 5; c++) begin
            step();
            if (ack0 || ack1) begin
                port_seq[n] = ack1;
                if (ack0) begin
                    checks++;
                    if (rdata0 !== (addr0 ^ 8'hB5)) begin
                        errors++;
                        $display("FAIL lock_rdata0 addr %h got %h exp %h", addr0, rdata0, addr0 ^ 8'hB5);
                    end
                    addr0 = addr0 + 8'h01;
                    if (addr0 == 8'h03) lock0 = 1'b0;
                    if (addr0 == 8'h04) req0 = 1'b0;
                end else begin
                    checks++;
                    if (rdata1 !== 8'hF5) begin
                        errors++;
                        $display("FAIL lock_rdata1 got %h exp f5", rdata1);
                    end
                    req1 = 1'b0;
                end
                n++;
            end
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL lock_timeout got %0d acks exp 5", n);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (port_seq[i] !== (i == 4)) begin
                    errors++;
                    $display("FAIL lock_order ack %0d got port %0d exp %0d", i, port_seq[i], (i == 4));
                end
            end
        end
        lock0 = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_access();
        int stray = 0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h55;
        step();
        step();
        checks++;
        if ({memread, busy} !== 2'b11) begin
            errors++;
            $display("FAIL rst_mid_pre got rd/busy=%b exp 11", {memread, busy});
        end
        reset = 1'b1; req0 = 1'b0;
        step();
        checks++;
        if ({memread, ack0, ack1, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_abort got rd/ack0/ack1/busy=%b exp 0000", {memread, ack0, ack1, busy});
        end
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (ack0 || ack1) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL rst_mid_stray_ack got %0d exp 0", stray);
        end
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h66;
        step();
        checks++;
        if ({memread, owner} !== 2'b11 || mar !== 8'h66) begin
            errors++;
            $display("FAIL rst_mid_regrant got rd/own=%b mar=%h exp 11 mar=66", {memread, owner}, mar);
        end
        step();
        step();
        checks++;
        if ({ack1, ack0} !== 2'b10 || rdata1 !== 8'hD3) begin
            errors++;
            $display("FAIL rst_mid_serve got ack1/ack0=%b rdata1=%h exp 10 d3", {ack1, ack0}, rdata1);
        end
        req1 = 1'b0;
        step();
    endtask

    task automatic test_lat1();
        int cyc_at[4];
        int n = 0;
        b_req0 = 1'b1; b_we0 = 1'b0; b_addr0 = 8'h70;
        for (int c = 1; c <= 30 && n < 4; c++) begin
            step();
            if (b_memread) begin
                checks++;
                if (b_mar !== b_addr0) begin
                    errors++;
                    $display("FAIL lat1_mar cyc %0d got %h exp %h", c, b_mar, b_addr0);
                end
            end
            if (b_ack1) begin
                checks++;
                errors++;
                $display("FAIL lat1_ack1 cyc %0d got 1 exp 0", c);
            end
            if (b_ack0) begin
                cyc_at[n] = c;
                checks++;
                if (b_rdata0 !== (b_addr0 ^ 8'hB5)) begin
                    errors++;
                    $display("FAIL lat1_rdata addr %h got %h exp %h", b_addr0, b_rdata0, b_addr0 ^ 8'hB5);
                end
                b_addr0 = b_addr0 + 8'h01;
                n++;
                if (n == 4) b_req0 = 1'b0;
            end
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL lat1_timeout got %0d acks exp 4", n);
        end else begin
            checks++;
            if (cyc_at[0] != 2) begin
                errors++;
                $display("FAIL lat1_first_latency got %0d exp 2", cyc_at[0]);
            end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (cyc_at[i] - cyc_at[i-1] != 3) begin
                    errors++;
                    $display("FAIL lat1_gap %0d got %0d exp 3", i, cyc_at[i] - cyc_at[i-1]);
                end
            end
        end
        step();
    endtask

    initial begin
        reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        b_req0 = 0; b_req1 = 0; b_we0 = 0; b_we1 = 0; b_lock0 = 0; b_lock1 = 0;
        b_addr0 = 0; b_addr1 = 0; b_wdata0 = 0; b_wdata1 = 0;
        test_reset();
        test_port0_read();
        test_port1_write();
        test_round_robin();
        test_lock();
        test_reset_mid_access();
        test_lat1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
